// File: rtl/serial_frame_sender_if.sv
// Request/serial-line bundle for serial_frame_sender.
// master = request source (bench or board glue); slave = the sender itself.
interface serial_frame_sender_if;
  logic        clkEn;
  logic        start;
  logic [1:0]  port;
  logic [3:0]  len;
  logic [14:0] data;
  logic        ready;
  logic        busy;
  logic        SerOut;
  logic        done;

  modport master (
    output clkEn, start, port, len, data,
    input  ready, busy, SerOut, done
  );

  modport slave (
    input  clkEn, start, port, len, data,
    output ready, busy, SerOut, done
  );
endinterface

// File: rtl/serial_frame_sender.sv
// Serial frame generator: start bit, 2-bit port, 4-bit length, N data bits, GAP_BITS idle ones.
// Optional even-parity bit after the data when SERIAL_FRAME_PARITY_EN is defined.
module serial_frame_sender #(
  parameter int GAP_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_frame_sender_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] ADDR  = 3'd2;
  localparam logic [2:0] LEN   = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] GAP   = 3'd6;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam logic [2:0] PAR   = 3'd5;
  localparam logic [2:0] POST_DATA = PAR;
`else
  localparam logic [2:0] POST_DATA = GAP;
`endif

  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic        ser;
  logic        done_q;
  logic [1:0]  port_r;
  logic [3:0]  len_r;
  logic [14:0] data_r;

`ifdef SERIAL_FRAME_PARITY_EN
  // Only the N transmitted data bits contribute to parity.
  logic [14:0] data_mask;
  logic        parity;
  assign data_mask = 15'((16'd1 << len_r) - 16'd1);
  assign parity    = (^port_r) ^ (^len_r) ^ (^(data_r & data_mask));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      ser    <= 1'b1;
      done_q <= 1'b0;
      port_r <= 2'd0;
      len_r  <= 4'd0;
      data_r <= 15'd0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        // Capture is independent of clkEn; the first bit waits for the next enable.
        if (bus.start) begin
          port_r <= bus.port;
          len_r  <= bus.len;
          data_r <= bus.data;
          state  <= START;
        end
      end else if (bus.clkEn) begin
        case (state)
          START: begin
            ser   <= 1'b0;
            state <= ADDR;
            cnt   <= 4'd1;
          end
          ADDR: begin
            ser <= port_r[cnt[0]];
            if (cnt == 4'd0) begin
              state <= LEN;
              cnt   <= 4'd3;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          LEN: begin
            ser <= len_r[cnt[1:0]];
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else if (len_r == 4'd0) begin
              state <= POST_DATA;
              cnt   <= GAP_LAST;
            end else begin
              state <= DATA;
              cnt   <= len_r - 4'd1;
            end
          end
          DATA: begin
            ser <= data_r[cnt];
            if (cnt == 4'd0) begin
              state <= POST_DATA;
              cnt   <= GAP_LAST;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
`ifdef SERIAL_FRAME_PARITY_EN
          PAR: begin
            ser   <= parity;
            state <= GAP;
            cnt   <= GAP_LAST;
          end
`endif
          GAP: begin
            // The last gap one is already on the line; the idle level carries it on.
            ser <= 1'b1;
            if (cnt == 4'd0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 4'd0;
            ser   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.ready  = (state == IDLE);
  assign bus.busy   = (state != IDLE);
  assign bus.SerOut = ser;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_serial_frame_sender.sv
// Directed bench for serial_frame_sender (default build, GAP_BITS=2).
module tb_serial_frame_sender;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_cnt;

  serial_frame_sender_if bus ();

  serial_frame_sender #(.GAP_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  port;
    logic [3:0]  len;
    logic [14:0] data;
    logic [31:0] bits;   // frame bits, first-sent bit at index n-1
    int          n;      // enable edges up to done
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input int per, input bit inject, input string tag);
    int   clks;
    int   d0;
    logic prev;
    logic expb;
    d0 = done_cnt;
    bus.port  = v.port;
    bus.len   = v.len;
    bus.data  = v.data;
    bus.start = 1'b1;
    bus.clkEn = 1'b1;
    check1({tag, "_ready_pre"}, bus.ready, 1'b1);
    tick();
    bus.start = 1'b0;
    bus.port  = ~v.port;
    bus.len   = ~v.len;
    bus.data  = ~v.data;
    check1({tag, "_ser_after_capture"}, bus.SerOut, 1'b1);
    check1({tag, "_ready_after_capture"}, bus.ready, 1'b0);
    check1({tag, "_busy_after_capture"}, bus.busy, 1'b1);
    clks = 0;
    prev = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      for (int h = 0; h < per - 1; h++) begin
        bus.clkEn = 1'b0;
        tick();
        clks++;
        check1($sformatf("%s_hold%0d_%0d", tag, i, h), bus.SerOut, prev);
        check1($sformatf("%s_hold_done%0d_%0d", tag, i, h), bus.done, 1'b0);
      end
      bus.clkEn = 1'b1;
      if (inject && i == 5) begin
        bus.start = 1'b1;
        bus.port  = 2'b00;
      end
      tick();
      clks++;
      bus.start = 1'b0;
      expb = v.bits[v.n - 1 - i];
      check1($sformatf("%s_bit%0d", tag, i), bus.SerOut, expb);
      check1($sformatf("%s_done%0d", tag, i), bus.done, (i == v.n - 1));
      check1($sformatf("%s_busy%0d", tag, i), bus.busy, (i != v.n - 1));
      prev = expb;
    end
    checkn({tag, "_clks_to_done"}, clks, v.n * per);
    bus.clkEn = 1'b1;
    repeat (3) tick();
    check1({tag, "_ready_post"}, bus.ready, 1'b1);
    check1({tag, "_ser_post"}, bus.SerOut, 1'b1);
    checkn({tag, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    checks   = 0;
    errors   = 0;
    done_cnt = 0;

    vecs[0] = '{2'b11, 4'b0100, 15'h0006, 32'b0_11_0100_0110_11, 13};
    vecs[1] = '{2'b01, 4'b0000, 15'h7FFF, 32'b0_01_0000_11, 9};
    vecs[2] = '{2'b10, 4'b1111, 15'h4001, 32'b0_10_1111_100000000000001_11, 24};
    vecs[3] = '{2'b00, 4'b0001, 15'h7FFE, 32'b0_00_0001_0_11, 10};
    vecs[4] = '{2'b01, 4'b0011, 15'h0005, 32'b0_01_0011_101_11, 12};

    rst       = 1'b1;
    bus.clkEn = 1'b0;
    bus.start = 1'b0;
    bus.port  = 2'd0;
    bus.len   = 4'd0;
    bus.data  = 15'd0;
    repeat (2) tick();
    rst = 1'b0;
    check1("reset_ser", bus.SerOut, 1'b1);
    check1("reset_ready", bus.ready, 1'b1);
    check1("reset_busy", bus.busy, 1'b0);
    check1("reset_done", bus.done, 1'b0);

    for (int k = 0; k < 5; k++) run_frame(vecs[k], 1, 1'b0, $sformatf("vec%0d", k));

    run_frame(vecs[0], 4, 1'b0, "rate4");
    run_frame(vecs[0], 1, 1'b1, "busy_reject");

    // Abort in the middle of the data bits.
    d0 = done_cnt;
    bus.port  = 2'b11;
    bus.len   = 4'b0100;
    bus.data  = 15'h0006;
    bus.start = 1'b1;
    bus.clkEn = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    check1("abort_in_data_ser", bus.SerOut, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("abort_ser", bus.SerOut, 1'b1);
    check1("abort_ready", bus.ready, 1'b1);
    check1("abort_done", bus.done, 1'b0);
    repeat (6) tick();
    checkn("abort_no_done", done_cnt - d0, 0);
    check1("abort_idle_ser", bus.SerOut, 1'b1);
    run_frame(vecs[0], 1, 1'b0, "after_abort");

    // rst and start together: nothing is captured.
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    check1("rst_start_ready", bus.ready, 1'b1);
    repeat (4) tick();
    check1("rst_start_ser", bus.SerOut, 1'b1);
    check1("rst_start_ready_later", bus.ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
